// File: rtl/sha3_host_driver.sv
// rtl/sha3_host_driver.sv - host-side SHA3 absorb/pad/start/collect sequencer
//
// Purpose: accepts a byte-oriented message as 64-bit beats, writes it into the
// hash core input FIFO with pad10*1 applied out to a full rate block, pulses
// start, waits for the core to finish and captures the digest words.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   msg_valid/msg_ready/msg_data    message beat handshake and payload
//   msg_last/msg_bytes              final beat marker and its valid byte count
//   wr_fifo/fifo_data               registered FIFO write strobe and word
//   start                           one-cycle hash start pulse
//   finish_hash/result_data         core completion and result word stream
//   digest/digest_valid             captured digest and its update pulse
//   busy                            high whenever not idle
module sha3_host_driver #(
  parameter int RATE_WORDS   = 17,
  parameter int DIGEST_WORDS = 4,
  parameter int RESULT_LAT   = 2   // must be at least 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      msg_valid,
  output logic                      msg_ready,
  input  logic [63:0]               msg_data,
  input  logic                      msg_last,
  input  logic [3:0]                msg_bytes,
  output logic                      wr_fifo,
  output logic [63:0]               fifo_data,
  output logic                      start,
  input  logic                      finish_hash,
  input  logic [63:0]               result_data,
  output logic [64*DIGEST_WORDS-1:0] digest,
  output logic                      digest_valid,
  output logic                      busy
);

  localparam int IW = $clog2(RATE_WORDS + 1);
  localparam int CW = $clog2(RESULT_LAT + DIGEST_WORDS + 1);
  localparam int DW = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(RATE_WORDS - 1);
  localparam logic [63:0]   END_BIT  = 64'h8000_0000_0000_0000;
  localparam logic [63:0]   PAD_BYTE = 64'h06;

  typedef enum logic [2:0] {
    S_IDLE, S_ABSORB, S_PAD, S_START, S_WAIT, S_COLLECT, S_DONE
  } state_t;

  state_t                          state_q, state_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic                            pad06_q, pad06_d;   // next PAD word still owes the 0x06 byte
  logic                            wr_q, wr_d;
  logic [63:0]                     data_q, data_d;
  logic                            start_q, start_d;
  logic [CW-1:0]                   cyc_q, cyc_d;
  logic [DIGEST_WORDS-1:0][63:0]   res_q, res_d;
  logic [64*DIGEST_WORDS-1:0]      digest_q, digest_d;

  logic          accept;
  logic          at_end;
  logic [IW-1:0] idx_inc;
  logic [3:0]    eff_bytes;
  logic [6:0]    shamt;
  logic [63:0]   mask;
  logic [DW-1:0] widx;

  assign msg_ready    = reset_n && (state_q == S_IDLE || state_q == S_ABSORB);
  assign accept       = msg_valid && msg_ready;
  assign at_end       = (idx_q == LAST_IDX);
  assign idx_inc      = at_end ? '0 : idx_q + IW'(1);
  assign eff_bytes    = (msg_bytes > 4'd8) ? 4'd8 : msg_bytes;
  assign shamt        = {eff_bytes[2:0], 3'b000};
  assign mask         = (64'd1 << shamt) - 64'd1;
  assign widx         = DW'(cyc_q - CW'(RESULT_LAT - 1));

  assign wr_fifo      = wr_q;
  assign fifo_data    = data_q;
  assign start        = start_q;
  assign digest       = digest_q;
  assign digest_valid = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pad06_d  = pad06_q;
    wr_d     = 1'b0;
    data_d   = data_q;
    start_d  = 1'b0;
    cyc_d    = cyc_q;
    res_d    = res_q;
    digest_d = digest_q;
    case (state_q)
      S_IDLE, S_ABSORB: begin
        if (accept) begin
          wr_d  = 1'b1;
          idx_d = idx_inc;
          if (!msg_last) begin
            data_d  = msg_data;
            state_d = S_ABSORB;
          end else if (eff_bytes == 4'd8) begin
            // A full final word leaves no room for 0x06; it goes in a PAD word.
            data_d  = msg_data;
            pad06_d = 1'b1;
            state_d = S_PAD;
          end else begin
            data_d  = (msg_data & mask) | (PAD_BYTE << shamt) | (at_end ? END_BIT : 64'd0);
            pad06_d = 1'b0;
            state_d = at_end ? S_START : S_PAD;
          end
        end
      end
      S_PAD: begin
        wr_d    = 1'b1;
        data_d  = (pad06_q ? PAD_BYTE : 64'd0) | (at_end ? END_BIT : 64'd0);
        pad06_d = 1'b0;
        idx_d   = idx_inc;
        if (at_end) state_d = S_START;
      end
      S_START: begin
        // start is registered so it lands one cycle after the final write.
        start_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (finish_hash) begin
          cyc_d   = '0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        cyc_d = cyc_q + CW'(1);
        if (cyc_q >= CW'(RESULT_LAT - 1)) begin
          res_d[widx] = result_data;
          if (widx == DW'(DIGEST_WORDS - 1)) begin
            digest_d = res_d;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      pad06_q  <= 1'b0;
      wr_q     <= 1'b0;
      data_q   <= '0;
      start_q  <= 1'b0;
      cyc_q    <= '0;
      res_q    <= '0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pad06_q  <= pad06_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
      start_q  <= start_d;
      cyc_q    <= cyc_d;
      res_q    <= res_d;
      digest_q <= digest_d;
    end
  end

endmodule

// File: tb/tb_sha3_host_driver.sv
// tb/tb_sha3_host_driver.sv - scoreboard bench for sha3_host_driver
module tb_sha3_host_driver;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         msg_valid = 1'b0;
  logic         msg_last = 1'b0;
  logic [63:0]  msg_data = '0;
  logic [3:0]   msg_bytes = '0;
  logic         finish_hash = 1'b0;
  logic [63:0]  result_data = '0;
  logic         msg_ready, wr_fifo, start, digest_valid, busy;
  logic [63:0]  fifo_data;
  logic [255:0] digest;

  sha3_host_driver dut (
    .clk(clk), .reset_n(reset_n),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .msg_last(msg_last), .msg_bytes(msg_bytes),
    .wr_fifo(wr_fifo), .fifo_data(fifo_data), .start(start),
    .finish_hash(finish_hash), .result_data(result_data),
    .digest(digest), .digest_valid(digest_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [63:0]  exp_q[$];
  logic [255:0] exp_dig_q[$];
  int           pending_starts = 0;
  logic         prev_wr = 1'b0, prev_start = 1'b0, prev_dv = 1'b0;
  logic [255:0] last_dig = '0;
  logic [7:0]   mb[$];
  bit           junk_en = 1'b1;

  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Monitor: compares every DUT output event against the scoreboard queues.
  always @(negedge clk) begin
    if (reset_n) begin
      if (wr_fifo) begin
        chk("wr_without_start", {255'd0, start}, 256'd0);
        chk("busy_while_writing", {255'd0, busy}, 256'd1);
        if (exp_q.size() == 0) chk("wr_unexpected", {192'd0, fifo_data}, 256'd0 - 256'd1);
        else chk("fifo_word", {192'd0, fifo_data}, {192'd0, exp_q.pop_front()});
      end
      if (start) begin
        chk("start_after_last_write", {254'd0, prev_wr, exp_q.size() == 0}, 256'd3);
        chk("start_single_cycle", {255'd0, prev_start}, 256'd0);
        chk("start_expected", {255'd0, pending_starts > 0}, 256'd1);
        if (pending_starts > 0) pending_starts--;
      end
      if (digest_valid) begin
        if (exp_dig_q.size() == 0) chk("digest_unexpected", 256'd1, 256'd0);
        else chk("digest_value", digest, exp_dig_q.pop_front());
      end
      if (prev_dv) chk("dv_pulse_then_idle", {254'd0, digest_valid, busy}, 256'd0);
    end
    prev_wr    <= wr_fifo && reset_n;
    prev_start <= start && reset_n;
    prev_dv    <= digest_valid && reset_n;
  end

  task automatic drive_beat(input logic [63:0] d, input logic last, input logic [3:0] nb);
    int g;
    @(negedge clk);
    if ($urandom_range(0, 3) == 0) begin
      msg_valid = 1'b0;
      @(negedge clk);
    end
    msg_valid   = 1'b1;
    msg_data    = d;
    msg_last    = last;
    msg_bytes   = nb;
    finish_hash = 1'($urandom_range(0, 1));  // must be ignored outside WAIT
    g = 0;
    while (!msg_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!msg_ready) chk("msg_ready_timeout", 256'd0, 256'd1);
  endtask

  // Reference model: byte-level pad10*1 over the whole message, 136-byte blocks.
  task automatic send_msg();
    int len, total, nbeats, lb, idx;
    logic [7:0]  p[];
    logic [63:0] w;
    logic [3:0]  nb;
    len   = mb.size();
    total = ((len + 1 + 135) / 136) * 136;
    p = new[total];
    for (int i = 0; i < total; i++) p[i] = (i < len) ? mb[i] : 8'h00;
    p[len]       = p[len] ^ 8'h06;
    p[total - 1] = p[total - 1] ^ 8'h80;
    for (int k = 0; k < total / 8; k++) begin
      for (int b = 0; b < 8; b++) w[8*b +: 8] = p[8*k + b];
      exp_q.push_back(w);
    end
    pending_starts++;
    nbeats = (len == 0) ? 1 : (len + 7) / 8;
    for (int k = 0; k < nbeats; k++) begin
      for (int b = 0; b < 8; b++) begin
        idx = 8*k + b;
        w[8*b +: 8] = (idx < len) ? mb[idx] : (junk_en ? 8'($urandom) : 8'h00);
      end
      if (k == nbeats - 1) begin
        lb = len - 8*(nbeats - 1);
        nb = 4'(lb);
        if (lb == 8 && $urandom_range(0, 1) == 1) nb = 4'($urandom_range(9, 15));
        drive_beat(w, 1'b1, nb);
      end else begin
        drive_beat(w, 1'b0, 4'($urandom));
      end
    end
    @(negedge clk);
    msg_valid   = 1'b0;
    msg_last    = 1'b0;
    finish_hash = 1'b0;
  endtask

  task automatic hash_cycle();
    int g;
    logic [63:0]  wd[4];
    logic [255:0] dg;
    g = 0;
    while (!start && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!start) chk("start_timeout", 256'd0, 256'd1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wd[i] = {$urandom, $urandom};
      dg[64*i +: 64] = wd[i];
    end
    exp_dig_q.push_back(dg);
    last_dig = dg;
    finish_hash = 1'b1;
    result_data = {$urandom, $urandom};
    @(negedge clk);
    finish_hash = 1'b0;
    result_data = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      result_data = wd[i];
    end
    @(negedge clk);
    result_data = {$urandom, $urandom};
    g = 0;
    while (!digest_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!digest_valid) chk("digest_timeout", 256'd0, 256'd1);
    repeat (3) @(negedge clk);
    chk("digest_held", digest, last_dig);
  endtask

  task automatic fill_random(input int len);
    mb.delete();
    for (int i = 0; i < len; i++) mb.push_back(8'($urandom));
  endtask

  initial begin
    #12;
    chk("reset_outputs", {msg_ready, wr_fifo, start, digest_valid, busy}, 256'd0);
    chk("reset_fifo_data", {192'd0, fifo_data}, 256'd0);
    chk("reset_digest", digest, 256'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {255'd0, msg_ready}, 256'd1);

    // Empty message
    junk_en = 1'b1; mb.delete();
    send_msg(); hash_cycle();
    // "abc"
    junk_en = 1'b0; mb = '{8'h61, 8'h62, 8'h63};
    send_msg(); hash_cycle();
    // 135 bytes of 0xFF: final word lands at the last rate index
    mb.delete();
    for (int i = 0; i < 135; i++) mb.push_back(8'hFF);
    send_msg(); hash_cycle();
    // 136 bytes: padding spills into a second block
    junk_en = 1'b1; fill_random(136);
    send_msg(); hash_cycle();
    // Random lengths
    for (int t = 0; t < 8; t++) begin
      fill_random($urandom_range(0, 300));
      send_msg(); hash_cycle();
    end

    // Reset during PAD: everything pending is discarded
    fill_random(40);
    send_msg();
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_outputs", {wr_fifo, start, busy, msg_ready, digest_valid}, 256'd0);
    chk("midreset_digest", digest, 256'd0);
    exp_q.delete();
    pending_starts = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", {255'd0, msg_ready}, 256'd1);
    repeat (40) @(negedge clk);
    chk("idle_after_midreset", {255'd0, busy}, 256'd0);

    fill_random($urandom_range(1, 200));
    send_msg(); hash_cycle();

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", {exp_q.size() == 0, exp_dig_q.size() == 0, pending_starts == 0}, 256'd7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
